// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: d = a - b (mod 2^WIDTH) with a final borrow.
//   A single full-subtractor cell consumes one operand bit per clock, LSB first.
//   A start/busy/done handshake lets a controller launch an operation and
//   collect the result later.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset; clears state and outputs
//   start  in   launch request, honoured only while idle
//   a      in   WIDTH-bit minuend, captured with start
//   b      in   WIDTH-bit subtrahend, captured with start
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when d/bo are updated
//   d      out  WIDTH-bit difference, held until the next completion
//   bo     out  borrow out of the MSB (1 iff a < b unsigned)
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Full-subtractor cell: returns {borrow_out, diff_bit}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    logic diff_bit;
    logic bout;
    diff_bit = x ^ y ^ bin;
    bout     = (~x & y) | (~(x ^ y) & bin);
    return {bout, diff_bit};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bo_q, bo_d;

  logic             dbit;
  logic             br_nxt;
  logic [WIDTH-1:0] sd_shift;
  logic             last_bit;

  always_comb begin
    {br_nxt, dbit} = full_sub(sa_q[0], sb_q[0], br_q);
    // Result bits enter from the MSB side so that after WIDTH shifts the
    // first (LSB) difference bit has reached position 0.
    sd_shift = {dbit, sd_q[WIDTH-1:1]};
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    bo_d    = bo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          sd_d    = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sd_d  = sd_shift;
        br_d  = br_nxt;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          // Publish straight from the shifted value so d is valid in DONE.
          res_d   = sd_shift;
          bo_d    = br_nxt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // start is deliberately ignored here; only IDLE honours it.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      bo_q    <= bo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign d    = res_q;
  assign bo   = bo_q;

endmodule
